// File: rtl/relu_vec_axis_tx.sv
// Captures one packed activation vector on an IN_VALID pulse and streams it out
// as an AXI4-Stream packet, one element per beat, with TLAST on the final element.
module relu_vec_axis_tx #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_OF_INPUTS = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                IN_VALID,
  input  logic [DATA_WIDTH*NUM_OF_INPUTS-1:0] IN_BITS,
  output logic [DATA_WIDTH-1:0]               M_AXIS_TDATA,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TLAST,
  output logic                                BUSY,
  output logic                                OVERFLOW,
  input  logic                                CLR_OVERFLOW
);

  localparam int IDXW = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OF_INPUTS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                   state;
  logic [NUM_OF_INPUTS-1:0][DATA_WIDTH-1:0] vec;
  logic [IDXW-1:0]                          idx;
  logic [IDXW-1:0]                          idx_nxt;
  logic                                     hs_last;
  logic                                     capture;
  logic                                     drop;

  assign idx_nxt = idx + 1'b1;
  // A pulse landing on the final handshake chains straight into the next packet.
  assign hs_last = (state == SEND) && M_AXIS_TREADY && (idx == LAST_IDX);
  assign capture = IN_VALID && ((state == IDLE) || hs_last);
  assign drop    = IN_VALID && !capture;
  assign BUSY    = (state == SEND);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      vec           <= '0;
      idx           <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      OVERFLOW      <= 1'b0;
    end else begin
      if (drop)              OVERFLOW <= 1'b1;
      else if (CLR_OVERFLOW) OVERFLOW <= 1'b0;

      if (capture) begin
        state         <= SEND;
        vec           <= IN_BITS;
        idx           <= '0;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= IN_BITS[DATA_WIDTH-1:0];
        M_AXIS_TLAST  <= (LAST_IDX == '0);
      end else if ((state == SEND) && M_AXIS_TREADY) begin
        if (idx == LAST_IDX) begin
          state         <= IDLE;
          idx           <= '0;
          M_AXIS_TVALID <= 1'b0;
          M_AXIS_TLAST  <= 1'b0;
        end else begin
          idx          <= idx_nxt;
          M_AXIS_TDATA <= vec[idx_nxt];
          M_AXIS_TLAST <= (idx_nxt == LAST_IDX);
        end
      end
    end
  end

endmodule
